demux_dispatch_ctrl: RTL and testbench

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

---
 rtl/demux_dispatch_ctrl_pkg.sv | 13 +
 rtl/demux_dispatch_ctrl_out_reg.sv | 38 +++
 rtl/demux_dispatch_ctrl.sv | 109 ++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and default sizing for the 1:2 burst dispatcher.
package demux_dispatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_BURST = 4;

endpackage

// File: rtl/demux_dispatch_ctrl_out_reg.sv
// One output-channel holding register: loads a beat, holds it while stalled,
// and clears valid once the consumer takes it.
module out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too, so a discarded beat can never
      // reappear on the bus after reset.
      data_q  <= '0;
    end else if (load_i) begin
      // A load wins over a drain in the same cycle: the new beat replaces the old.
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Burst dispatcher: routes BURST beats to y0, then BURST beats to y1, and so on,
// through two independently draining output registers.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BURST = DEFAULT_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             y0_valid,
  output logic [WIDTH-1:0] y0_data,
  input  logic             y0_ready,
  output logic             y1_valid,
  output logic [WIDTH-1:0] y1_data,
  input  logic             y1_ready,
  output logic             sel,
  output logic [3:0]       cnt
);

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       xfer;
  logic       load0, load1;

  // The target register can accept when it is empty or being drained this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    in_ready = 1'b0;
    unique case (state_q)
      ROUTE0:  in_ready = en & (~y0_valid | y0_ready);
      ROUTE1:  in_ready = en & (~y1_valid | y1_ready);
      default: in_ready = 1'b0;
    endcase
  end

  assign xfer  = in_valid & in_ready;
  assign load0 = xfer & (state_q == ROUTE0);
  assign load1 = xfer & (state_q == ROUTE1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (en) state_d = ROUTE0;
      end
      ROUTE0, ROUTE1: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (xfer) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = 4'd0;
            state_d = (state_q == ROUTE0) ? ROUTE1 : ROUTE0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = (state_q == ROUTE1);
  assign cnt = cnt_q;

  out_reg #(.WIDTH(WIDTH)) u_y0 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load0),
    .ready_i (y0_ready),
    .data_i  (in_data),
    .valid_o (y0_valid),
    .data_o  (y0_data)
  );

  out_reg #(.WIDTH(WIDTH)) u_y1 (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load1),
    .ready_i (y1_ready),
    .data_i  (in_data),
    .valid_o (y1_valid),
    .data_o  (y1_data)
  );

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench: vector table on a BURST=4 instance plus a short
// alternation sequence on a BURST=1 instance.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // BURST=4 instance
  logic       rst, en, in_valid, in_ready, y0_valid, y1_valid, y0_ready, y1_ready, sel;
  logic [7:0] in_data, y0_data, y1_data;
  logic [3:0] cnt;

  // BURST=1 instance
  logic       b_rst, b_en, b_in_valid, b_in_ready, b_y0_valid, b_y1_valid, b_sel;
  logic [7:0] b_in_data, b_y0_data, b_y1_data;
  logic [3:0] b_cnt;

  demux_dispatch_ctrl #(.WIDTH(8), .BURST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .y0_valid(y0_valid), .y0_data(y0_data), .y0_ready(y0_ready),
    .y1_valid(y1_valid), .y1_data(y1_data), .y1_ready(y1_ready), .sel(sel), .cnt(cnt)
  );

  demux_dispatch_ctrl #(.WIDTH(8), .BURST(1)) dut_b1 (
    .clk(clk), .rst(b_rst), .en(b_en), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .y0_valid(b_y0_valid), .y0_data(b_y0_data), .y0_ready(1'b1),
    .y1_valid(b_y1_valid), .y1_data(b_y1_data), .y1_ready(1'b1), .sel(b_sel), .cnt(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs applied before the edge; exp_rdy is in_ready before the edge,
  // the remaining expectations are the registered outputs after the edge.
  typedef struct {
    logic       rst, en, vin;
    logic [7:0] din;
    logic       r0, r1;
    logic       exp_rdy, exp_sel;
    logic [3:0] exp_cnt;
    logic       exp_v0;
    logic [7:0] exp_d0;
    logic       exp_v1;
    logic [7:0] exp_d1;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  initial begin
    // full burst on each channel, one beat per cycle
    vecs[0]  = '{1'b0,1'b1,1'b1,8'h01,1'b1,1'b1, 1'b0,1'b0,4'd0,1'b0,8'h00,1'b0,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b1,8'h01,1'b1,1'b1, 1'b1,1'b0,4'd1,1'b1,8'h01,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b1,1'b1,8'h02,1'b1,1'b1, 1'b1,1'b0,4'd2,1'b1,8'h02,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b1,1'b1,8'h03,1'b1,1'b1, 1'b1,1'b0,4'd3,1'b1,8'h03,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b1,1'b1,8'h04,1'b1,1'b1, 1'b1,1'b1,4'd0,1'b1,8'h04,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b1,1'b1,8'h05,1'b1,1'b1, 1'b1,1'b1,4'd1,1'b0,8'h04,1'b1,8'h05};
    vecs[6]  = '{1'b0,1'b1,1'b1,8'h06,1'b1,1'b1, 1'b1,1'b1,4'd2,1'b0,8'h04,1'b1,8'h06};
    vecs[7]  = '{1'b0,1'b1,1'b1,8'h07,1'b1,1'b1, 1'b1,1'b1,4'd3,1'b0,8'h04,1'b1,8'h07};
    vecs[8]  = '{1'b0,1'b1,1'b1,8'h08,1'b1,1'b1, 1'b1,1'b0,4'd0,1'b0,8'h04,1'b1,8'h08};
    vecs[9]  = '{1'b0,1'b1,1'b0,8'h08,1'b1,1'b1, 1'b1,1'b0,4'd0,1'b0,8'h04,1'b0,8'h08};
    // y0 stall holding 0xA5, then drain and accept in the same cycle
    vecs[10] = '{1'b0,1'b1,1'b1,8'hA5,1'b0,1'b1, 1'b1,1'b0,4'd1,1'b1,8'hA5,1'b0,8'h08};
    vecs[11] = '{1'b0,1'b1,1'b1,8'h11,1'b0,1'b1, 1'b0,1'b0,4'd1,1'b1,8'hA5,1'b0,8'h08};
    vecs[12] = '{1'b0,1'b1,1'b1,8'h11,1'b0,1'b1, 1'b0,1'b0,4'd1,1'b1,8'hA5,1'b0,8'h08};
    vecs[13] = '{1'b0,1'b1,1'b1,8'h11,1'b1,1'b1, 1'b1,1'b0,4'd2,1'b1,8'h11,1'b0,8'h08};
    // en drop after 2 beats, restart at ROUTE0
    vecs[14] = '{1'b0,1'b0,1'b1,8'h22,1'b1,1'b1, 1'b0,1'b0,4'd0,1'b0,8'h11,1'b0,8'h08};
    vecs[15] = '{1'b0,1'b1,1'b1,8'h22,1'b1,1'b1, 1'b0,1'b0,4'd0,1'b0,8'h11,1'b0,8'h08};
    vecs[16] = '{1'b0,1'b1,1'b1,8'h22,1'b1,1'b1, 1'b1,1'b0,4'd1,1'b1,8'h22,1'b0,8'h08};
    // switch to y1 while y0 is stalled on its 4th beat
    vecs[17] = '{1'b0,1'b1,1'b1,8'h23,1'b1,1'b1, 1'b1,1'b0,4'd2,1'b1,8'h23,1'b0,8'h08};
    vecs[18] = '{1'b0,1'b1,1'b1,8'h24,1'b1,1'b1, 1'b1,1'b0,4'd3,1'b1,8'h24,1'b0,8'h08};
    vecs[19] = '{1'b0,1'b1,1'b1,8'h25,1'b1,1'b1, 1'b1,1'b1,4'd0,1'b1,8'h25,1'b0,8'h08};
    vecs[20] = '{1'b0,1'b1,1'b1,8'h26,1'b0,1'b1, 1'b1,1'b1,4'd1,1'b1,8'h25,1'b1,8'h26};
    vecs[21] = '{1'b0,1'b1,1'b1,8'h27,1'b0,1'b1, 1'b1,1'b1,4'd2,1'b1,8'h25,1'b1,8'h27};
    vecs[22] = '{1'b0,1'b1,1'b0,8'h27,1'b1,1'b1, 1'b1,1'b1,4'd2,1'b0,8'h25,1'b0,8'h27};
    // reset mid-burst with y1 stalled
    vecs[23] = '{1'b0,1'b1,1'b1,8'h28,1'b1,1'b0, 1'b1,1'b1,4'd3,1'b0,8'h25,1'b1,8'h28};
    vecs[24] = '{1'b1,1'b1,1'b1,8'h29,1'b1,1'b0, 1'b0,1'b0,4'd0,1'b0,8'h00,1'b0,8'h00};
    vecs[25] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,4'd0,1'b0,8'h00,1'b0,8'h00};
  end

  task automatic check_regs(input string tag, input logic e_sel, input logic [3:0] e_cnt,
                            input logic e_v0, input logic [7:0] e_d0,
                            input logic e_v1, input logic [7:0] e_d1);
    check({tag, " sel"}, 32'(sel), 32'(e_sel));
    check({tag, " cnt"}, 32'(cnt), 32'(e_cnt));
    check({tag, " y0_valid"}, 32'(y0_valid), 32'(e_v0));
    check({tag, " y0_data"},  32'(y0_data),  32'(e_d0));
    check({tag, " y1_valid"}, 32'(y1_valid), 32'(e_v1));
    check({tag, " y1_data"},  32'(y1_data),  32'(e_d1));
  endtask

  task automatic b1_step(input string tag, input logic [7:0] d, input logic e_sel,
                         input logic e_v0, input logic [7:0] e_d0,
                         input logic e_v1, input logic [7:0] e_d1);
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data  = d;
    #1;
    check({tag, " in_ready"}, 32'(b_in_ready), 32'd1);
    @(posedge clk);
    #1;
    check({tag, " sel"}, 32'(b_sel), 32'(e_sel));
    check({tag, " cnt"}, 32'(b_cnt), 32'd0);
    check({tag, " y0_valid"}, 32'(b_y0_valid), 32'(e_v0));
    check({tag, " y0_data"},  32'(b_y0_data),  32'(e_d0));
    check({tag, " y1_valid"}, 32'(b_y1_valid), 32'(e_v1));
    check({tag, " y1_data"},  32'(b_y1_data),  32'(e_d1));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'hFF; y0_ready = 1'b0; y1_ready = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check_regs("reset", 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00);

    @(negedge clk);
    rst = 1'b0; en = 1'b0; in_valid = 1'b0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      en       = vecs[i].en;
      in_valid = vecs[i].vin;
      in_data  = vecs[i].din;
      y0_ready = vecs[i].r0;
      y1_ready = vecs[i].r1;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].exp_sel, vecs[i].exp_cnt,
                 vecs[i].exp_v0, vecs[i].exp_d0, vecs[i].exp_v1, vecs[i].exp_d1);
    end

    // BURST=1: target alternates on every transfer
    @(negedge clk);
    b_rst = 1'b0; b_en = 1'b1;
    @(posedge clk);
    #1;
    check("b1 idle->route0 sel", 32'(b_sel), 32'd0);
    b1_step("b1 0x10", 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00);
    b1_step("b1 0x11", 8'h11, 1'b0, 1'b0, 8'h10, 1'b1, 8'h11);
    b1_step("b1 0x12", 8'h12, 1'b1, 1'b1, 8'h12, 1'b0, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
